// File: rtl/xls_pipe_share_sched.sv
// Round-robin sharing of one fixed-latency XLS pipeline among NUM_REQ requesters.
// Optional XLS_PIPE_SCHED_STATS_EN adds issue / credit-stall counters.
module xls_pipe_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int RES_W      = 32,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      pipe_in_valid,
  output logic [DATA_W-1:0]         pipe_in_data,
  input  logic                      pipe_out_valid,
  input  logic [RES_W-1:0]          pipe_out_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      sched_err
`ifdef XLS_PIPE_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_credit_stall
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {WARMUP, RUN} state_t;

  state_t            state;
  logic [WW-1:0]     wcnt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   gnt_id;
  logic              found;
  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]   tag_id [LATENCY];
  logic [CW-1:0]     count;
  logic [CW-1:0]     inflight;
  logic              has_credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic              full;
  logic              do_push;
  logic              err_now;
  logic [ID_W-1:0]   mem_id   [FIFO_DEPTH];
  logic [RES_W-1:0]  mem_data [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Search starts just past the last grantee so every requester gets a turn.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++)
      inflight = inflight + CW'(tag_v[k]);
  end

  assign has_credit = (count + inflight) < CW'(FIFO_DEPTH);
  assign issue = (state == RUN) && has_credit && (|req_valid);
  assign req_ready = issue ? (NUM_REQ'(1) << gnt_id) : '0;
  assign pipe_in_valid = issue;
  assign pipe_in_data = req_data[int'(gnt_id)*DATA_W +: DATA_W];

  assign rsp_valid = (count != '0);
  assign rsp_id    = mem_id[rd_ptr];
  assign rsp_data  = mem_data[rd_ptr];
  assign pop       = rsp_valid && rsp_ready;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push      = tag_v[LATENCY-1];
  assign do_push   = push && (!full || pop);
  assign err_now   = ((state == RUN) && (pipe_out_valid != tag_v[LATENCY-1]))
                   || (push && full && !pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WARMUP;
      wcnt   <= '0;
      ptr    <= ID_W'(NUM_REQ - 1);
      tag_v  <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      sched_err <= 1'b0;
      for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_id[k]   <= '0;
        mem_data[k] <= '0;
      end
    end else begin
      // The pipeline's valid chain is unreset; wait it out before trusting it.
      if (state == WARMUP) begin
        if (wcnt == WW'(LATENCY - 1)) state <= RUN;
        else wcnt <= wcnt + 1'b1;
      end
      if (issue) ptr <= gnt_id;
      tag_v[0]  <= issue;
      tag_id[0] <= gnt_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      if (do_push) begin
        mem_id[wr_ptr]   <= tag_id[LATENCY-1];
        mem_data[wr_ptr] <= pipe_out_data;
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(pop);
      if (err_now) sched_err <= 1'b1;
    end
  end

`ifdef XLS_PIPE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued       <= '0;
      stat_credit_stall <= '0;
    end else begin
      if (issue && stat_issued != '1)
        stat_issued <= stat_issued + 1'b1;
      if ((state == RUN) && (|req_valid) && !has_credit
          && stat_credit_stall != '1)
        stat_credit_stall <= stat_credit_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_xls_pipe_share_sched.sv
// Directed bench for xls_pipe_share_sched with a 2-stage pipeline model.
// Expected grants, latencies and results are hand-derived.
module tb_xls_pipe_share_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [127:0] req_data;
  logic        pipe_in_valid;
  logic [31:0] pipe_in_data;
  logic        pipe_out_valid;
  logic [31:0] pipe_out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        sched_err;
`ifdef XLS_PIPE_SCHED_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_credit_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic        force_ov = 1'b0;
  logic [1:0]  pv = '0;
  logic [31:0] pd0 = '0;
  logic [31:0] pd1 = '0;
  logic [33:0] rsp_log [$];

  always #5 clk = ~clk;

  xls_pipe_share_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .pipe_in_valid  (pipe_in_valid),
    .pipe_in_data   (pipe_in_data),
    .pipe_out_valid (pipe_out_valid),
    .pipe_out_data  (pipe_out_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .sched_err      (sched_err)
`ifdef XLS_PIPE_SCHED_STATS_EN
    ,
    .stat_issued       (stat_issued),
    .stat_credit_stall (stat_credit_stall)
`endif
  );

  function automatic logic [31:0] f(input logic [31:0] x);
    return x * 32'd3 + 32'h1000;
  endfunction

  // Unreset 2-cycle pipeline model
  always @(posedge clk) begin
    pv  <= {pv[0], pipe_in_valid};
    pd0 <= f(pipe_in_data);
    pd1 <= pd0;
  end
  assign pipe_out_valid = pv[1] | force_ov;
  assign pipe_out_data  = pd1;

  always @(negedge clk)
    if (rst_n && rsp_valid && rsp_ready)
      rsp_log.push_back({rsp_id, rsp_data});

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] log_at(input int i);
    return (i < rsp_log.size()) ? rsp_log[i] : '1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_iss;
    int n_res;
    logic [1:0] eid;
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_piv", pipe_in_valid, 0);
    check("rst_rspv", rsp_valid, 0);
    check("rst_err", sched_err, 0);

    // Warmup, then round-robin over all four requesters
    req_valid = 4'hF;
    req_data = {32'h103, 32'h102, 32'h101, 32'h100};
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("warm1", req_ready, 0);
    @(negedge clk); check("warm2", req_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_gnt", req_ready, 64'(4'b0001 << (i % 4)));
      check("rr_data", pipe_in_data, 64'(32'h100 + (i % 4)));
      if (i == 2) check("rr_rsp_early", rsp_valid, 0);
      if (i == 3) check("rr_rsp_first", rsp_valid, 1);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (8) @(negedge clk);
    check("rr_nrsp", rsp_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      eid = 2'(i % 4);
      check("rr_rsp", log_at(i), {eid, f(32'h100 + 32'(i % 4))});
    end

    // Single op from requester 1: response exactly three cycles later
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_data[63:32] = 32'h2A;
    @(negedge clk); check("lat_gnt", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk); check("lat_t1", rsp_valid, 0);
    @(negedge clk); check("lat_t2", rsp_valid, 0);
    @(negedge clk);
    check("lat_t3", rsp_valid, 1);
    check("lat_id", rsp_id, 1);
    check("lat_data", rsp_data, f(32'h2A));

    // Backpressure: credits cap outstanding work at FIFO depth
    @(posedge clk); #1;
    rsp_log.delete();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_data[31:0] = 32'h55;
    n_iss = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready[0]) n_iss++;
    end
    check("bp_issues", n_iss, 4);
    check("bp_ready", req_ready, 0);
    check("bp_full_rsp", rsp_valid, 1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    n_res = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_ready[0]) n_res++;
    end
    check("bp_resume", n_res > 0, 1);
    n_iss = n_iss + n_res;
    @(posedge clk); #1 req_valid = '0;
    repeat (10) @(negedge clk);
    check("bp_nrsp", rsp_log.size(), n_iss);
    for (int i = 0; i < n_iss; i++)
      check("bp_rsp", log_at(i), {2'd0, f(32'h55)});
    check("bp_err", sched_err, 0);

    // Spurious pipeline output with nothing in flight
    @(posedge clk); #1 force_ov = 1'b1;
    @(posedge clk); #1 force_ov = 1'b0;
    @(negedge clk); check("err_set", sched_err, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", sched_err, 1);

    // Reset with two ops in flight
    @(posedge clk); #1;
    req_valid = 4'b1100;
    req_data[127:64] = {32'h77, 32'h66};
    @(negedge clk); check("mid_gnt2", req_ready, 4'b0100);
    @(negedge clk); check("mid_gnt3", req_ready, 4'b1000);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_ready", req_ready, 0);
    check("mid_piv", pipe_in_valid, 0);
    check("mid_rspv", rsp_valid, 0);
    check("mid_err", sched_err, 0);
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_log.delete();
    repeat (10) @(negedge clk);
    check("post_nrsp", rsp_log.size(), 0);
    check("post_rspv", rsp_valid, 0);
    check("post_err", sched_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
